otter_trap_ctrl: RTL and testbench

- Machine-mode trap controller directly downstream of the address/exception checker.
- Consumes the checker's exception select and trap value, plus the ecall, mret and external-interrupt sources.
- Owns the trap CSRs: mstatus.MIE/MPIE, mie.MEIE, mip.MEIP, mtvec, mepc, mcause, mtval, mscratch.
- Sequences trap entry and mret exit through a small FSM that redirects the PC and flushes the current instruction.

---
 rtl/otter_trap_ctrl_pkg.sv | 40 ++++
 rtl/otter_trap_ctrl_if.sv | 28 ++
 rtl/otter_sync_ff.sv | 15 +
 rtl/otter_trap_ctrl.sv | 106 ++++++++++
 tb/tb_otter_trap_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/otter_trap_ctrl_pkg.sv
// otter_trap_ctrl_pkg: CSR map, trap cause codes and FSM states for the machine-mode trap controller.
package otter_trap_ctrl_pkg;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam logic [3:0] MCAUSE_SEL_NONE           = 4'd0;
    localparam logic [3:0] MCAUSE_SEL_INST_MISALIGN  = 4'd1;
    localparam logic [3:0] MCAUSE_SEL_ILLEGAL        = 4'd2;
    localparam logic [3:0] MCAUSE_SEL_BREAKPOINT     = 4'd3;
    localparam logic [3:0] MCAUSE_SEL_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] MCAUSE_SEL_STORE_MISALIGN = 4'd5;

    localparam logic [31:0] MCAUSE_INST_MISALIGN  = 32'd0;
    localparam logic [31:0] MCAUSE_ILLEGAL        = 32'd2;
    localparam logic [31:0] MCAUSE_BREAKPOINT     = 32'd3;
    localparam logic [31:0] MCAUSE_LOAD_MISALIGN  = 32'd4;
    localparam logic [31:0] MCAUSE_STORE_MISALIGN = 32'd6;
    localparam logic [31:0] MCAUSE_ECALL_M        = 32'd11;
    localparam logic [31:0] MCAUSE_MEXT_INT       = 32'h8000_000B;

    typedef enum logic [1:0] {
        TRAP_ST_RUN,
        TRAP_ST_TRAP,
        TRAP_ST_EXIT
    } trap_st_t;

    // Unknown nonzero selects are reported as illegal instructions.
    function automatic logic [31:0] excp_code(input logic [3:0] sel);
        return sel == MCAUSE_SEL_INST_MISALIGN  ? MCAUSE_INST_MISALIGN :
               sel == MCAUSE_SEL_BREAKPOINT     ? MCAUSE_BREAKPOINT :
               sel == MCAUSE_SEL_LOAD_MISALIGN  ? MCAUSE_LOAD_MISALIGN :
               sel == MCAUSE_SEL_STORE_MISALIGN ? MCAUSE_STORE_MISALIGN : MCAUSE_ILLEGAL;
    endfunction
endpackage

// File: rtl/otter_trap_ctrl_if.sv
// otter_trap_ctrl_if: pipeline-facing signals of the trap controller (trap sources, CSR port, redirect).
interface otter_trap_ctrl_if;
    logic        i_instrn_valid;
    logic [3:0]  i_excp_sel;
    logic [31:0] i_trap_mtval;
    logic [31:0] i_pc_addr;
    logic        i_ecall;
    logic        i_mret;
    logic        i_ext_intr;
    logic        i_csr_we;
    logic [11:0] i_csr_addr;
    logic [31:0] i_csr_wdata;
    logic [31:0] o_csr_rdata;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_busy;

    modport master (
        output i_instrn_valid, i_excp_sel, i_trap_mtval, i_pc_addr, i_ecall, i_mret,
               i_ext_intr, i_csr_we, i_csr_addr, i_csr_wdata,
        input  o_csr_rdata, o_redirect, o_redirect_pc, o_busy
    );
    modport slave (
        input  i_instrn_valid, i_excp_sel, i_trap_mtval, i_pc_addr, i_ecall, i_mret,
               i_ext_intr, i_csr_we, i_csr_addr, i_csr_wdata,
        output o_csr_rdata, o_redirect, o_redirect_pc, o_busy
    );
endinterface

// File: rtl/otter_sync_ff.sv
// otter_sync_ff: multi-flop synchronizer for a single asynchronous level.
module otter_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;
    always_ff @(posedge clk or posedge rst)
        if (rst) chain <= '0;
        else     chain <= {chain[STAGES-2:0], d};
    assign q = chain[STAGES-1];
endmodule

// File: rtl/otter_trap_ctrl.sv
// otter_trap_ctrl: machine-mode trap CSRs plus the RUN/TRAP/EXIT sequencer that redirects the PC.
module otter_trap_ctrl
    import otter_trap_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input logic i_clk,
    input logic i_rst,
    otter_trap_ctrl_if.slave bus
);
    trap_st_t    state;
    logic        meip, mie_b, mpie, meie;
    logic [31:0] mtvec, mepc, mcause, mtval, mscratch;
    logic        run_v, int_pend, is_exc, take_trap, take_mret, csr_wr;
    logic [31:0] trap_cause, trap_val, trap_pc, base;

    otter_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(i_clk),
        .rst(i_rst),
        .d  (bus.i_ext_intr),
        .q  (meip)
    );

    assign run_v      = state == TRAP_ST_RUN && bus.i_instrn_valid;
    assign int_pend   = meip & meie & mie_b;
    assign is_exc     = bus.i_excp_sel != MCAUSE_SEL_NONE;
    assign take_trap  = run_v && (int_pend || is_exc || bus.i_ecall);
    assign take_mret  = run_v && bus.i_mret && !take_trap;
    assign csr_wr     = run_v && bus.i_csr_we && !take_trap;
    assign trap_cause = int_pend ? MCAUSE_MEXT_INT : is_exc ? excp_code(bus.i_excp_sel) : MCAUSE_ECALL_M;
    assign trap_val   = !int_pend && is_exc ? bus.i_trap_mtval : '0;
    assign base       = {mtvec[31:2], 2'b00};
    // Only interrupts are vectored; the cause's top bit is dropped from the offset.
    assign trap_pc    = int_pend && mtvec[1:0] == 2'b01 ? base + {trap_cause[29:0], 2'b00} : base;

    always_comb begin
        bus.o_csr_rdata = '0;
        case (bus.i_csr_addr)
            CSR_MSTATUS:  bus.o_csr_rdata = {24'b0, mpie, 3'b0, mie_b, 3'b0};
            CSR_MIE:      bus.o_csr_rdata = {20'b0, meie, 11'b0};
            CSR_MIP:      bus.o_csr_rdata = {20'b0, meip, 11'b0};
            CSR_MTVEC:    bus.o_csr_rdata = mtvec;
            CSR_MSCRATCH: bus.o_csr_rdata = mscratch;
            CSR_MEPC:     bus.o_csr_rdata = mepc;
            CSR_MCAUSE:   bus.o_csr_rdata = mcause;
            CSR_MTVAL:    bus.o_csr_rdata = mtval;
            default:      bus.o_csr_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= TRAP_ST_RUN;
            mie_b             <= 1'b0;
            mpie              <= 1'b0;
            meie              <= 1'b0;
            mtvec             <= RESET_MTVEC;
            mepc              <= '0;
            mcause            <= '0;
            mtval             <= '0;
            mscratch          <= '0;
            bus.o_redirect    <= 1'b0;
            bus.o_redirect_pc <= '0;
            bus.o_busy        <= 1'b0;
        end else begin
            if (csr_wr)
                case (bus.i_csr_addr)
                    CSR_MSTATUS:  {mpie, mie_b} <= {bus.i_csr_wdata[7], bus.i_csr_wdata[3]};
                    CSR_MIE:      meie <= bus.i_csr_wdata[11];
                    CSR_MTVEC:    mtvec <= {bus.i_csr_wdata[31:2], 1'b0, bus.i_csr_wdata[0]};
                    CSR_MSCRATCH: mscratch <= bus.i_csr_wdata;
                    CSR_MEPC:     mepc <= {bus.i_csr_wdata[31:2], 2'b00};
                    CSR_MCAUSE:   mcause <= bus.i_csr_wdata;
                    CSR_MTVAL:    mtval <= bus.i_csr_wdata;
                    default:      ;
                endcase
            case (state)
                TRAP_ST_RUN:
                    if (take_trap) begin
                        mepc              <= bus.i_pc_addr;
                        mcause            <= trap_cause;
                        mtval             <= trap_val;
                        mpie              <= mie_b;
                        mie_b             <= 1'b0;
                        bus.o_redirect    <= 1'b1;
                        bus.o_redirect_pc <= trap_pc;
                        bus.o_busy        <= 1'b1;
                        state             <= TRAP_ST_TRAP;
                    end else if (take_mret) begin
                        mie_b             <= mpie;
                        mpie              <= 1'b1;
                        bus.o_redirect    <= 1'b1;
                        bus.o_redirect_pc <= {mepc[31:2], 2'b00};
                        bus.o_busy        <= 1'b1;
                        state             <= TRAP_ST_EXIT;
                    end
                default: begin
                    bus.o_redirect <= 1'b0;
                    bus.o_busy     <= 1'b0;
                    state          <= TRAP_ST_RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_otter_trap_ctrl.sv
// tb_otter_trap_ctrl: directed vectors with hand-computed expectations for the trap controller.
module tb_otter_trap_ctrl;
    import otter_trap_ctrl_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;
    logic [31:0] v;

    otter_trap_ctrl_if bus();

    otter_trap_ctrl #(.RESET_MTVEC(32'h0), .SYNC_STAGES(2)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_instrn_valid = 0;
        bus.i_excp_sel     = 0;
        bus.i_trap_mtval   = 0;
        bus.i_pc_addr      = 0;
        bus.i_ecall        = 0;
        bus.i_mret         = 0;
        bus.i_csr_we       = 0;
        bus.i_csr_addr     = 0;
        bus.i_csr_wdata    = 0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        bus.i_csr_addr = a;
        #1;
        d = bus.o_csr_rdata;
    endtask

    task automatic csr_w(input logic [11:0] a, input logic [31:0] d);
        bus.i_instrn_valid = 1;
        bus.i_csr_we       = 1;
        bus.i_csr_addr     = a;
        bus.i_csr_wdata    = d;
        tick();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        bus.i_ext_intr = 0;
        repeat (2) tick();
        chk("rst_redirect", {31'b0, bus.o_redirect}, 0);
        chk("rst_busy", {31'b0, bus.o_busy}, 0);
        chk("rst_rpc", bus.o_redirect_pc, 0);
        rd(CSR_MTVEC, v);   chk("rst_mtvec", v, 0);
        rd(CSR_MSTATUS, v); chk("rst_mstatus", v, 0);
        rst = 0;
        tick();

        bus.i_instrn_valid = 1; bus.i_excp_sel = 4; bus.i_trap_mtval = 32'h1003; bus.i_pc_addr = 32'h200;
        tick();
        idle();
        chk("ld_redirect", {31'b0, bus.o_redirect}, 1);
        chk("ld_busy", {31'b0, bus.o_busy}, 1);
        chk("ld_rpc", bus.o_redirect_pc, 0);
        rd(CSR_MEPC, v);    chk("ld_mepc", v, 32'h200);
        rd(CSR_MCAUSE, v);  chk("ld_mcause", v, 4);
        rd(CSR_MTVAL, v);   chk("ld_mtval", v, 32'h1003);
        rd(CSR_MSTATUS, v); chk("ld_mstatus", v, 0);
        tick();
        chk("ld_redirect_drop", {31'b0, bus.o_redirect}, 0);
        chk("ld_busy_drop", {31'b0, bus.o_busy}, 0);

        csr_w(CSR_MIE, 32'h800);
        csr_w(CSR_MTVEC, 32'h103);
        rd(CSR_MTVEC, v);   chk("mtvec_bit1", v, 32'h101);
        csr_w(CSR_MSTATUS, 32'h8);
        bus.i_instrn_valid = 1; bus.i_pc_addr = 32'h204; bus.i_ext_intr = 1;
        tick();
        bus.i_ext_intr = 0;
        chk("int_e1", {31'b0, bus.o_redirect}, 0);
        tick();
        chk("int_e2", {31'b0, bus.o_redirect}, 0);
        rd(CSR_MIP, v);     chk("int_mip", v, 32'h800);
        tick();
        idle();
        chk("int_redirect", {31'b0, bus.o_redirect}, 1);
        chk("int_rpc", bus.o_redirect_pc, 32'h12C);
        rd(CSR_MCAUSE, v);  chk("int_mcause", v, 32'h8000_000B);
        rd(CSR_MEPC, v);    chk("int_mepc", v, 32'h204);
        rd(CSR_MSTATUS, v); chk("int_mstatus", v, 32'h80);
        tick();

        bus.i_instrn_valid = 1; bus.i_mret = 1;
        tick();
        idle();
        chk("mret_redirect", {31'b0, bus.o_redirect}, 1);
        chk("mret_rpc", bus.o_redirect_pc, 32'h204);
        chk("mret_busy", {31'b0, bus.o_busy}, 1);
        rd(CSR_MSTATUS, v); chk("mret_mstatus", v, 32'h88);
        tick();
        chk("mret_busy_drop", {31'b0, bus.o_busy}, 0);

        bus.i_ext_intr = 1;
        repeat (2) tick();
        bus.i_instrn_valid = 1; bus.i_excp_sel = 2; bus.i_trap_mtval = 32'hDEAD; bus.i_pc_addr = 32'h300;
        tick();
        idle();
        chk("both_rpc", bus.o_redirect_pc, 32'h12C);
        rd(CSR_MCAUSE, v);  chk("both_mcause", v, 32'h8000_000B);
        rd(CSR_MTVAL, v);   chk("both_mtval", v, 0);
        rd(CSR_MEPC, v);    chk("both_mepc", v, 32'h300);
        tick();

        bus.i_instrn_valid = 1; bus.i_mret = 1;
        tick();
        chk("late_exit_rpc", bus.o_redirect_pc, 32'h300);
        bus.i_mret = 0; bus.i_pc_addr = 32'h500;
        rd(CSR_MSTATUS, v); chk("late_mstatus", v, 32'h88);
        tick();
        chk("late_no_trap_in_exit", {31'b0, bus.o_redirect}, 0);
        tick();
        chk("late_int_redirect", {31'b0, bus.o_redirect}, 1);
        chk("late_int_rpc", bus.o_redirect_pc, 32'h12C);
        rd(CSR_MEPC, v);    chk("late_int_mepc", v, 32'h500);
        bus.i_ext_intr = 0;
        idle();
        repeat (3) tick();

        csr_w(CSR_MEPC, 32'h403);
        rd(CSR_MEPC, v);    chk("mepc_align", v, 32'h400);
        csr_w(CSR_MSCRATCH, 32'hCAFE_F00D);
        rd(CSR_MSCRATCH, v); chk("mscratch", v, 32'hCAFE_F00D);
        rd(12'h7C0, v);     chk("unmapped", v, 0);
        bus.i_instrn_valid = 1; bus.i_ecall = 1; bus.i_pc_addr = 32'h600; bus.i_trap_mtval = 32'hBEEF;
        bus.i_csr_we = 1; bus.i_csr_addr = CSR_MEPC; bus.i_csr_wdata = 32'h777;
        tick();
        idle();
        chk("ecall_rpc", bus.o_redirect_pc, 32'h100);
        rd(CSR_MEPC, v);    chk("ecall_mepc", v, 32'h600);
        rd(CSR_MCAUSE, v);  chk("ecall_mcause", v, 11);
        rd(CSR_MTVAL, v);   chk("ecall_mtval", v, 0);
        tick();

        bus.i_instrn_valid = 1; bus.i_ecall = 1;
        tick();
        idle();
        chk("pre_rst_redirect", {31'b0, bus.o_redirect}, 1);
        #2 rst = 1;
        #1;
        chk("arst_redirect", {31'b0, bus.o_redirect}, 0);
        chk("arst_busy", {31'b0, bus.o_busy}, 0);
        chk("arst_rpc", bus.o_redirect_pc, 0);
        rd(CSR_MTVEC, v);   chk("arst_mtvec", v, 0);
        rd(CSR_MEPC, v);    chk("arst_mepc", v, 0);
        rd(CSR_MCAUSE, v);  chk("arst_mcause", v, 0);
        rd(CSR_MSCRATCH, v); chk("arst_mscratch", v, 0);
        rd(CSR_MIE, v);     chk("arst_mie", v, 0);
        tick();
        rst = 0;
        tick();
        chk("post_rst_redirect", {31'b0, bus.o_redirect}, 0);
        bus.i_instrn_valid = 1; bus.i_ecall = 1;
        tick();
        idle();
        chk("post_rst_trap", {31'b0, bus.o_redirect}, 1);
        chk("post_rst_rpc", bus.o_redirect_pc, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
